// File: rtl/riscv_pkg.sv
// Shared pipeline definitions for the RISC-V core.
//   XLEN                - datapath width
//   TIMEOUT_CYC_DEFAULT - default data-memory wait budget (cycles) per access
//   mem_state_t         - MEM-stage stall controller states
package riscv_pkg;

    localparam int unsigned XLEN                = 32;
    localparam int unsigned TIMEOUT_CYC_DEFAULT = 64;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2,
        DONE = 2'd3
    } mem_state_t;

endpackage

// File: rtl/flop_en_rst_cl.sv
// Register with synchronous active-high reset, synchronous clear and load enable.
// Priority: rst > clr > en.
//   clk  - clock
//   rst  - synchronous reset to zero
//   clr  - synchronous clear to zero
//   en   - load d
//   d, q - data in / registered data out
module flop_en_rst_cl #(
    parameter int unsigned W = 32
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);

    logic [W-1:0] q_d;

    always_comb begin
        q_d = q;
        if (clr) begin
            q_d = '0;
        end else if (en) begin
            q_d = d;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            q <= '0;
        end else begin
            q <= q_d;
        end
    end

endmodule

// File: rtl/mem_stall_ctrl.sv
// MEM-stage data-memory access controller. Issues one request per load/store,
// stalls the front of the pipeline until the response arrives (or the wait
// budget expires), then retires the instruction for exactly one cycle.
//   clk, rst                         - clock, synchronous active-high reset
//   EXMEM_valid, MemReadM, MemWriteM - MEM-stage instruction qualifiers
//   ALUResultM, WriteDataM           - access address and store data
//   dreq_*                           - request channel to data memory
//   dresp_*                          - response channel from data memory
//   StallMem                         - freezes PC, IF/ID, ID/EX, EX/MEM
//   MemValidW                        - valid forwarded to MEM/WB
//   ReadDataM                        - load data (hold register)
//   MemFault                         - one-cycle pulse on bus error / timeout
//   stall_cnt                        - saturating count of stalled cycles
//
// state | meaning
// IDLE  | no access pending; issues request in the same cycle acc rises
// REQ   | request presented, waiting for dreq_ready
// RESP  | request accepted, waiting for dresp_valid
// DONE  | access finished; instruction retires, MemFault if it failed
module mem_stall_ctrl
    import riscv_pkg::*;
#(
    parameter int unsigned XLEN        = riscv_pkg::XLEN,
    parameter int unsigned TIMEOUT_CYC = riscv_pkg::TIMEOUT_CYC_DEFAULT
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            EXMEM_valid,
    input  logic            MemReadM,
    input  logic            MemWriteM,
    input  logic [XLEN-1:0] ALUResultM,
    input  logic [XLEN-1:0] WriteDataM,
    output logic            dreq_valid,
    output logic            dreq_we,
    output logic [XLEN-1:0] dreq_addr,
    output logic [XLEN-1:0] dreq_wdata,
    input  logic            dreq_ready,
    input  logic            dresp_valid,
    input  logic            dresp_err,
    input  logic [XLEN-1:0] dresp_rdata,
    output logic            StallMem,
    output logic            MemValidW,
    output logic [XLEN-1:0] ReadDataM,
    output logic            MemFault,
    output logic [31:0]     stall_cnt
);

    localparam logic [7:0] WAIT_LAST = 8'(TIMEOUT_CYC - 1);

    mem_state_t      state_q, state_d;
    logic [7:0]      wait_q, wait_d;
    logic            fault_q, fault_d;
    logic [31:0]     stall_cnt_q, stall_cnt_d;
    logic            acc;
    logic            hold_en, hold_clr;
    logic            req_raw, stall_raw, valid_raw;
    logic [XLEN-1:0] hold_q;

    always_comb begin
        acc       = EXMEM_valid & (MemReadM | MemWriteM);
        state_d   = state_q;
        wait_d    = wait_q;
        fault_d   = 1'b0;
        hold_en   = 1'b0;
        hold_clr  = 1'b0;
        req_raw   = 1'b0;
        stall_raw = 1'b0;
        valid_raw = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (acc) begin
                    req_raw   = 1'b1;
                    stall_raw = 1'b1;
                    wait_d    = 8'd0;
                    state_d   = dreq_ready ? RESP : REQ;
                end else begin
                    valid_raw = EXMEM_valid;
                end
            end
            REQ: begin
                req_raw   = 1'b1;
                stall_raw = 1'b1;
                // Budget exhausted: abandon even if ready arrives this cycle.
                if (wait_q == WAIT_LAST) begin
                    state_d  = DONE;
                    fault_d  = 1'b1;
                    hold_clr = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                    if (dreq_ready) begin
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                stall_raw = 1'b1;
                // A response in the final budget cycle still completes normally.
                if (dresp_valid) begin
                    state_d = DONE;
                    if (dresp_err) begin
                        fault_d  = 1'b1;
                        hold_clr = 1'b1;
                    end else begin
                        hold_en = MemReadM;
                    end
                end else if (wait_q == WAIT_LAST) begin
                    state_d  = DONE;
                    fault_d  = 1'b1;
                    hold_clr = 1'b1;
                end else begin
                    wait_d = wait_q + 8'd1;
                end
            end
            DONE: begin
                valid_raw = 1'b1;
                state_d   = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        stall_cnt_d = stall_cnt_q;
        if (StallMem && (stall_cnt_q != 32'hFFFF_FFFF)) begin
            stall_cnt_d = stall_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            wait_q      <= 8'd0;
            fault_q     <= 1'b0;
            stall_cnt_q <= 32'd0;
        end else begin
            state_q     <= state_d;
            wait_q      <= wait_d;
            fault_q     <= fault_d;
            stall_cnt_q <= stall_cnt_d;
        end
    end

    flop_en_rst_cl #(.W(XLEN)) u_hold (
        .clk (clk),
        .rst (rst),
        .clr (hold_clr),
        .en  (hold_en),
        .d   (dresp_rdata),
        .q   (hold_q)
    );

    // Outputs are forced quiet while rst is high, before state has cleared.
    assign dreq_valid = req_raw & ~rst;
    assign dreq_we    = MemWriteM;
    assign dreq_addr  = ALUResultM;
    assign dreq_wdata = WriteDataM;
    assign StallMem   = stall_raw & ~rst;
    assign MemValidW  = valid_raw & ~rst;
    assign MemFault   = (state_q == DONE) & fault_q & ~rst;
    assign ReadDataM  = hold_q;
    assign stall_cnt  = stall_cnt_q;

endmodule
